sys_clk_div_gen: RTL and testbench

Parametrised, synthesizable multi-channel clock-pattern generator driven from `sys_clk`. Each channel produces a square wave with a runtime-programmable half-period and start offset, counted in `sys_clk` cycles, plus glitch-free start and stop. It is the successor to the fixed single-output simulation clock source. It serves as a divided-clock and strobe source for BMD example logic and testbench harnesses.

---
 rtl/sys_clk_gen_pkg.sv | 18 +
 rtl/clk_gen_chan.sv | 153 +++++++++++++++
 rtl/sys_clk_div_gen.sv | 65 ++++++
 tb/tb_sys_clk_div_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-pattern generator.
package sys_clk_gen_pkg;

  localparam int unsigned MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFSET   = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } chan_state_e;

  // A half-period of zero would never toggle; treat it as one cycle.
  function automatic logic [MAX_CNT_W-1:0] clamp_half(input logic [MAX_CNT_W-1:0] half);
    return (half == '0) ? MAX_CNT_W'(1) : half;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One generator channel: offset/half-period counters, start/stop FSM and
// shadowed configuration that only takes effect on phase boundaries.
module clk_gen_chan
  import sys_clk_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_HALF   = 2,
  parameter int unsigned DEF_OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_start,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  input  logic [CNT_W-1:0] wr_offset,
  output logic             clk_out,
  output logic             clk_pulse,
  output logic             running,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_HALF   = CNT_W'(clamp_half(MAX_CNT_W'(DEF_HALF)));
  localparam logic [CNT_W-1:0] RST_OFFSET = CNT_W'(DEF_OFFSET);

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] half, half_nxt;
  logic [CNT_W-1:0] offset, offset_nxt;
  logic [CNT_W-1:0] sh_half, sh_half_nxt;
  logic [CNT_W-1:0] sh_offset, sh_offset_nxt;
  logic             pending_nxt;
  logic             out_nxt, pulse_nxt;
  logic [CNT_W-1:0] wr_half_cl;
  logic             restart, quiet, boundary;

  // State, counters, configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      half      <= RST_HALF;
      offset    <= RST_OFFSET;
      sh_half   <= RST_HALF;
      sh_offset <= RST_OFFSET;
      pending   <= 1'b0;
      clk_out   <= 1'b0;
      clk_pulse <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      half      <= half_nxt;
      offset    <= offset_nxt;
      sh_half   <= sh_half_nxt;
      sh_offset <= sh_offset_nxt;
      pending   <= pending_nxt;
      clk_out   <= out_nxt;
      clk_pulse <= pulse_nxt;
      running   <= (state_nxt == RUN) || (state_nxt == STOPPING);
    end
  end

  // Next-state: config shadowing first, then the channel FSM using the
  // configuration that is in force from this edge on.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    half_nxt      = half;
    offset_nxt    = offset;
    sh_half_nxt   = sh_half;
    sh_offset_nxt = sh_offset;
    pending_nxt   = pending;
    out_nxt       = clk_out;
    pulse_nxt     = 1'b0;

    wr_half_cl = CNT_W'(clamp_half(MAX_CNT_W'(wr_half)));
    restart    = sync_start && en;
    quiet      = (state == IDLE) || (state == OFFSET) || restart;
    boundary   = ((state == RUN) || (state == STOPPING)) && (cnt == '0);

    // Writes land directly while the waveform is idle, else wait for a toggle.
    if (wr_en) begin
      if (quiet) begin
        half_nxt   = wr_half_cl;
        offset_nxt = wr_offset;
      end else begin
        sh_half_nxt   = wr_half_cl;
        sh_offset_nxt = wr_offset;
        pending_nxt   = 1'b1;
      end
    end else if (pending && (quiet || boundary)) begin
      half_nxt    = sh_half;
      offset_nxt  = sh_offset;
      pending_nxt = 1'b0;
    end

    if (restart) begin
      state_nxt = OFFSET;
      cnt_nxt   = offset_nxt;
      out_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nxt = OFFSET;
            cnt_nxt   = offset_nxt;
          end
        end
        OFFSET: begin
          if (!en) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            // Leaving OFFSET already consumes one cycle of the first low phase.
            state_nxt = RUN;
            if (half_nxt == CNT_W'(1)) begin
              out_nxt   = 1'b1;
              pulse_nxt = 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = half_nxt - CNT_W'(2);
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (!en && !clk_out) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            out_nxt   = !clk_out;
            pulse_nxt = !clk_out;
            cnt_nxt   = half_nxt - CNT_W'(1);
            if (!en) state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
            if (!en) state_nxt = STOPPING;
          end
        end
        STOPPING: begin
          if (cnt == '0) begin
            out_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sys_clk_div_gen.sv
// Multi-channel clock-pattern generator: channel array plus config decode.
module sys_clk_div_gen
  import sys_clk_gen_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_HALF   = 2,
  parameter int unsigned DEF_OFFSET = 0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [CNT_W-1:0]  cfg_offset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_pulse,
  output logic [NUM_CH-1:0] ch_running
);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] pending;
  logic              ready_c;

  // Channel decode; out-of-range channels are accepted and dropped.
  always_comb begin
    wr_sel  = '0;
    ready_c = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        wr_sel[i] = 1'b1;
        ready_c   = !pending[i];
      end
    end
  end

  assign cfg_ready = ready_c;
  assign wr_en     = wr_sel & {NUM_CH{cfg_valid & ready_c}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_chan #(
      .CNT_W      (CNT_W),
      .DEF_HALF   (DEF_HALF),
      .DEF_OFFSET (DEF_OFFSET)
    ) u_chan (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .en         (ch_en[i]),
      .sync_start (sync_start),
      .wr_en      (wr_en[i]),
      .wr_half    (cfg_half),
      .wr_offset  (cfg_offset),
      .clk_out    (clk_out[i]),
      .clk_pulse  (clk_pulse[i]),
      .running    (ch_running[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_sys_clk_div_gen.sv
// Scoreboard bench: stimulus queues the edge numbers at which each channel
// must pulse; a negedge monitor pops and compares every observed pulse.
module tb_sys_clk_div_gen;

  localparam int unsigned NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_half, cfg_offset;
  logic [3:0]  ch_en;
  logic        sync_start;
  logic [3:0]  clk_out, clk_pulse, ch_running;

  // Second instance with a non-power-of-two channel count.
  logic        cfg3_valid, cfg3_ready;
  logic [1:0]  cfg3_ch;
  logic [15:0] cfg3_half, cfg3_offset;
  logic [2:0]  en3, out3, pulse3, run3;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_q[NCH][$];
  logic [3:0] mon_en   = 4'b0;
  logic [3:0] prev_out = 4'b0;
  int exp_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_clk_div_gen #(.NUM_CH(4), .CNT_W(16), .DEF_HALF(2), .DEF_OFFSET(0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_offset(cfg_offset), .ch_en(ch_en),
    .sync_start(sync_start), .clk_out(clk_out), .clk_pulse(clk_pulse), .ch_running(ch_running)
  );

  sys_clk_div_gen #(.NUM_CH(3), .CNT_W(16), .DEF_HALF(2), .DEF_OFFSET(0)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_half(cfg3_half), .cfg_offset(cfg3_offset), .ch_en(en3),
    .sync_start(1'b0), .clk_out(out3), .clk_pulse(pulse3), .ch_running(run3)
  );

  // Pulse monitor: compare each pulse against the queued edge number.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && mon_en[c]) begin
        if (clk_pulse[c]) begin
          n_chk++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL pulse_ch%0d: pulse at edge %0d, none expected", c, cyc);
          end else begin
            exp_e = exp_q[c].pop_front();
            if (exp_e != cyc) begin
              n_fail++;
              $display("FAIL pulse_ch%0d: pulse at edge %0d, expected edge %0d", c, cyc, exp_e);
            end
          end
        end else if (exp_q[c].size() != 0 && exp_q[c][0] <= cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL pulse_ch%0d: no pulse by edge %0d, expected edge %0d", c, cyc, exp_q[c][0]);
          void'(exp_q[c].pop_front());
        end
        if (clk_out[c] && !prev_out[c]) begin
          n_chk++;
          if (!clk_pulse[c]) begin
            n_fail++;
            $display("FAIL rise_pulse_ch%0d: clk_out rose at edge %0d with clk_pulse 0, expected 1", c, cyc);
          end
        end
      end
    end
    prev_out = clk_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rises(input int ch, input int first, input int per, input int n);
    for (int j = 0; j < n; j++) exp_q[ch].push_back(first + per * j);
  endtask

  // Issue one write; returns just after the accepting edge.
  task automatic cfg_write(input int ch, input int h, input int o);
    int waitc;
    waitc      = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_half   = 16'(h);
    cfg_offset = 16'(o);
    while (!cfg_ready && waitc < 100) begin
      tick(1);
      waitc++;
    end
    if (!cfg_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL cfg_write_timeout: cfg_ready 0 for ch %0d, expected 1", ch);
    end
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int e0, s, waitc;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_half = 16'd0; cfg_offset = 16'd0;
    ch_en = 4'b0; sync_start = 1'b0;
    cfg3_valid = 1'b0; cfg3_ch = 2'd0; cfg3_half = 16'd0; cfg3_offset = 16'd0; en3 = 3'b0;
    tick(3);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_clk_pulse", 32'(clk_pulse), 0);
    check("rst_running", 32'(ch_running), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    rst_n = 1'b1;

    // Channel 0 with defaults: half 2, offset 0.
    ch_en[0] = 1'b1; e0 = cyc + 1;
    push_rises(0, e0 + 2, 4, 4);
    mon_en[0] = 1'b1;
    tick(16);
    check("ch0_drained", 32'(exp_q[0].size()), 0);
    check("ch0_running", 32'(ch_running[0]), 1);
    mon_en[0] = 1'b0;

    // Channel 1 half 3 offset 5, then half 1 written during a high phase.
    cfg_write(1, 3, 5);
    ch_en[1] = 1'b1; e0 = cyc + 1;
    exp_q[1].push_back(e0 + 8);
    exp_q[1].push_back(e0 + 12);
    exp_q[1].push_back(e0 + 14);
    exp_q[1].push_back(e0 + 16);
    mon_en[1] = 1'b1;
    tick(8);
    check("ch1_low_before_rise", 32'(clk_out[1]), 0);
    tick(1);
    check("ch1_first_rise", 32'(clk_out[1]), 1);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 16'd1; cfg_offset = 16'd5;
    tick(1);
    cfg_valid = 1'b0;
    check("ch1_ready_stall", 32'(cfg_ready), 0);
    check("ch1_high_kept", 32'(clk_out[1]), 1);
    tick(1);
    check("ch1_high_kept2", 32'(clk_out[1]), 1);
    check("ch1_ready_stall2", 32'(cfg_ready), 0);
    tick(1);
    check("ch1_fall_old_half", 32'(clk_out[1]), 0);
    check("ch1_ready_back", 32'(cfg_ready), 1);
    tick(6);
    check("ch1_drained", 32'(exp_q[1].size()), 0);
    ch_en[1] = 1'b0; mon_en[1] = 1'b0;

    // Channel 2 half 4: drop enable one cycle into the high phase.
    cfg_write(2, 4, 0);
    ch_en[2] = 1'b1; e0 = cyc + 1;
    exp_q[2].push_back(e0 + 4);
    mon_en[2] = 1'b1;
    tick(5);
    check("ch2_rise", 32'(clk_out[2]), 1);
    ch_en[2] = 1'b0;
    tick(3);
    check("ch2_stop_high_held", 32'(clk_out[2]), 1);
    check("ch2_stop_running", 32'(ch_running[2]), 1);
    tick(1);
    check("ch2_stop_fall", 32'(clk_out[2]), 0);
    check("ch2_stop_idle", 32'(ch_running[2]), 0);
    tick(8);
    check("ch2_drained", 32'(exp_q[2].size()), 0);

    // Channels 0 (half 2) and 3 (half 3): sync_start during ch0 high phase.
    cfg_write(3, 3, 0);
    ch_en[3] = 1'b1;
    tick(3);
    waitc = 0;
    while (!clk_pulse[0] && waitc < 20) begin
      tick(1);
      waitc++;
    end
    check("ch0_found_rise", 32'(clk_pulse[0]), 1);
    sync_start = 1'b1; s = cyc + 1;
    tick(1);
    sync_start = 1'b0;
    push_rises(0, s + 2, 4, 3);
    push_rises(3, s + 3, 6, 2);
    mon_en[0] = 1'b1; mon_en[3] = 1'b1;
    check("sync_forced_low", 32'(clk_out), 0);
    check("sync_offset_state", 32'(ch_running), 0);
    tick(2);
    check("sync_s_plus_2", 32'(clk_out), 32'h1);
    tick(9);
    check("sync_ch0_drained", 32'(exp_q[0].size()), 0);
    check("sync_ch3_drained", 32'(exp_q[3].size()), 0);
    mon_en[0] = 1'b0; mon_en[3] = 1'b0;

    // Half 0 is treated as 1.
    cfg_write(1, 0, 0);
    ch_en[1] = 1'b1; e0 = cyc + 1;
    push_rises(1, e0 + 1, 2, 3);
    mon_en[1] = 1'b1;
    tick(7);
    check("half0_drained", 32'(exp_q[1].size()), 0);
    ch_en[1] = 1'b0; mon_en[1] = 1'b0;

    // Write to channel 3 of a 3-channel instance is dropped.
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_half = 16'd7; cfg3_offset = 16'd9;
    check("oob_ready", 32'(cfg3_ready), 1);
    tick(1);
    cfg3_valid = 1'b0;
    en3 = 3'b111; e0 = cyc + 1;
    tick(2);
    check("oob_low", 32'(out3), 0);
    tick(1);
    check("oob_default_rise", 32'(out3), 32'h7);
    tick(4);
    check("oob_second_rise", 32'(pulse3), 32'h7);

    // Reset mid-run with an update pending on channel 0.
    mon_en[2] = 1'b0;
    cfg_write(0, 5, 0);
    check("ch0_pending_ready", 32'(cfg_ready), 0);
    check("pre_rst_running", 32'(ch_running), 32'h9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 0);
    check("async_rst_pulse", 32'(clk_pulse), 0);
    check("async_rst_running", 32'(ch_running), 0);
    check("async_rst_ready", 32'(cfg_ready), 1);
    tick(2);
    rst_n = 1'b1; e0 = cyc + 1;
    push_rises(0, e0 + 2, 4, 2);
    push_rises(3, e0 + 2, 4, 2);
    mon_en[0] = 1'b1; mon_en[3] = 1'b1;
    tick(8);
    check("post_rst_ch0_drained", 32'(exp_q[0].size()), 0);
    check("post_rst_ch3_drained", 32'(exp_q[3].size()), 0);
    mon_en = 4'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
